// File: rtl/seg_display_arbiter.sv
// Request/grant arbiter sharing one 4-digit seven-segment display between three requesters,
// with minimum hold time, round-robin fairness, blank gap, digit scan and BCD decode.
module seg_display_arbiter #(
    parameter int SCAN_BITS    = 17,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [15:0] digits_0,
    input  logic [15:0] digits_1,
    input  logic [15:0] digits_2,
    output logic [2:0]  grant,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t               state_r, state_nx_s;
    logic [2:0]           grant_r, grant_nx_s;
    logic [1:0]           last_r, last_nx_s;
    logic [HW-1:0]        hold_r, hold_nx_s;
    logic [BW-1:0]        blank_r, blank_nx_s;
    logic [SCAN_BITS-1:0] scan_r;
    logic [6:0]           seg_r, seg_nx_s;
    logic [3:0]           an_r, an_nx_s;
    logic [1:0]           pick_s;
    logic                 preempt_s;
    logic [15:0]          bus_s;
    logic [3:0]           nibble_s;

    // Round-robin: first set request after the last owner, wrapping mod 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(last) + k) % 3);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'(3'b001 << idx);
    endfunction

    // Active-low gfedcba; non-decimal nibbles leave the digit dark.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign pick_s    = rr_pick(req, last_r);
    assign preempt_s = ((req & ~grant_r) != 3'b000) && (hold_r == HOLD_MAX);

    // Arbitration next-state logic; during GRANT last_r is the current owner.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        last_nx_s  = last_r;
        hold_nx_s  = hold_r;
        blank_nx_s = blank_r;
        case (state_r)
            S_IDLE: begin
                if (req != 3'b000) begin
                    state_nx_s = S_GRANT;
                    last_nx_s  = pick_s;
                    grant_nx_s = onehot(pick_s);
                    hold_nx_s  = {HW{1'b0}};
                end else begin
                    grant_nx_s = 3'b000;
                end
            end
            S_GRANT: begin
                if (!req[last_r] || preempt_s) begin
                    state_nx_s = S_BLANK;
                    grant_nx_s = 3'b000;
                    blank_nx_s = {BW{1'b0}};
                end else if (hold_r != HOLD_MAX) begin
                    hold_nx_s = hold_r + {{(HW-1){1'b0}}, 1'b1};
                end else begin
                    hold_nx_s = hold_r;
                end
            end
            S_BLANK: begin
                if (blank_r == BLANK_LAST) begin
                    if (req != 3'b000) begin
                        state_nx_s = S_GRANT;
                        last_nx_s  = pick_s;
                        grant_nx_s = onehot(pick_s);
                        hold_nx_s  = {HW{1'b0}};
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end else begin
                    blank_nx_s = blank_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                grant_nx_s = 3'b000;
            end
        endcase
    end

    // Select the owner's digit for the current scan slot and decode it.
    always_comb begin
        bus_s    = 16'h0000;
        nibble_s = 4'h0;
        seg_nx_s = 7'b1111111;
        an_nx_s  = 4'b1111;
        case (grant_r)
            3'b001:  bus_s = digits_0;
            3'b010:  bus_s = digits_1;
            3'b100:  bus_s = digits_2;
            default: bus_s = 16'h0000;
        endcase
        case (scan_r[SCAN_BITS-1 -: 2])
            2'd0:    begin nibble_s = bus_s[15:12]; an_nx_s = 4'b0111; end
            2'd1:    begin nibble_s = bus_s[11:8];  an_nx_s = 4'b1011; end
            2'd2:    begin nibble_s = bus_s[7:4];   an_nx_s = 4'b1101; end
            default: begin nibble_s = bus_s[3:0];   an_nx_s = 4'b1110; end
        endcase
        if (grant_r != 3'b000) begin
            seg_nx_s = decode(nibble_s);
        end else begin
            an_nx_s  = 4'b1111;
            seg_nx_s = 7'b1111111;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Arbitration counters, grant and owner history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= 3'b000;
            last_r  <= 2'd2;
            hold_r  <= {HW{1'b0}};
            blank_r <= {BW{1'b0}};
        end else begin
            grant_r <= grant_nx_s;
            last_r  <= last_nx_s;
            hold_r  <= hold_nx_s;
            blank_r <= blank_nx_s;
        end
    end

    // Free-running scan counter and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_r <= {SCAN_BITS{1'b0}};
            seg_r  <= 7'b1111111;
            an_r   <= 4'b1111;
        end else begin
            scan_r <= scan_r + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            seg_r  <= seg_nx_s;
            an_r   <= an_nx_s;
        end
    end

    assign grant = grant_r;
    assign seg   = seg_r;
    assign an    = an_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomised and directed bench for seg_display_arbiter; a behavioural model
// feeds a scoreboard queue that an independent monitor drains every cycle.
module tb_seg_display_arbiter;

    localparam int SB    = 4;
    localparam int HOLD  = 8;
    localparam int BLANK = 3;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [15:0] digits_0, digits_1, digits_2;
    logic [2:0]  grant;
    logic [6:0]  seg;
    logic [3:0]  an;

    int passed = 0;
    int total  = 0;

    logic [13:0] exp_q[$];

    seg_display_arbiter #(
        .SCAN_BITS(SB), .HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .digits_0(digits_0), .digits_1(digits_1), .digits_2(digits_2),
        .grant(grant), .seg(seg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: owner index, phase and time in phase, with plain integers.
    initial begin : model
        int phase;      // 0 idle, 1 granted, 2 blank
        int owner;      // -1 when nobody owns
        int last;
        int t;
        int scan;
        int digit_pos;
        int value;
        int others;
        logic [15:0] bus;
        logic [2:0]  g;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        phase = 0; owner = -1; last = 2; t = 0; scan = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                phase = 0; owner = -1; last = 2; t = 0; scan = 0;
                exp_q.push_back({3'b000, 4'b1111, 7'b1111111});
            end else begin
                e_an  = 4'b1111;
                e_seg = 7'b1111111;
                if (owner >= 0) begin
                    bus       = (owner == 0) ? digits_0 : (owner == 1) ? digits_1 : digits_2;
                    digit_pos = scan / (1 << (SB - 2));
                    value     = (bus >> (4 * (3 - digit_pos))) & 15;
                    e_an      = 4'b1111 & ~(4'b1000 >> digit_pos);
                    e_seg     = seg_of(value);
                end
                scan = (scan + 1) % (1 << SB);
                if (phase == 1) begin
                    others = req & ~(1 << owner);
                    if (!req[owner] || (others != 0 && t >= HOLD)) begin
                        phase = 2; owner = -1; t = 0;
                    end else begin
                        t = t + 1;
                    end
                end else if (phase == 2) begin
                    t = t + 1;
                    if (t == BLANK) begin
                        phase = 0;
                        t = 0;
                    end
                end
                if (phase == 0 && t == 0 && req != 3'b000 && owner < 0) begin
                    for (int k = 1; k <= 3; k++) begin
                        if (owner < 0 && req[(last + k) % 3]) owner = (last + k) % 3;
                    end
                    last  = owner;
                    phase = 1;
                end
                g = (owner >= 0) ? 3'(1 << owner) : 3'b000;
                exp_q.push_back({g, e_an, e_seg});
            end
        end
    end

    // Monitor: one expected response per clock, compared just after the edge.
    initial begin : monitor
        logic [13:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({grant, an, seg} === e) begin
                    passed++;
                end else begin
                    $display("FAIL scoreboard t=%0t grant/an/seg got %b/%b/%b expected %b/%b/%b",
                             $time, grant, an, seg, e[13:11], e[10:7], e[6:0]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic direct_check(input string name, input logic [13:0] got, input logic [13:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got %h expected %h", name, got, want);
    endtask

    initial begin : stimulus
        rst_n = 1'b0; req = 3'b000;
        digits_0 = 16'h5678; digits_1 = 16'h1234; digits_2 = 16'h0A0F;
        cycles(2);
        rst_n = 1'b1;
        cycles(20);                         // idle, display dark
        req = 3'b010;                       // bubble owns, shows 1234
        cycles(40);
        req = 3'b000;
        cycles(8);
        reset_pulse();
        req = 3'b001;
        cycles(3);
        req = 3'b011;                       // preemption after hold
        cycles(25);
        req = 3'b000;
        cycles(6);
        @(negedge clk); rst_n = 1'b0; req = 3'b111;
        @(negedge clk); rst_n = 1'b1;
        cycles(50);                         // full rotation 001,010,100,001
        req = 3'b000;
        cycles(6);
        reset_pulse();
        req = 3'b100;                       // selection, 0A0F
        cycles(36);
        req = 3'b000;
        cycles(6);
        for (int n = 0; n < 60; n++) begin
            req      = 3'($urandom_range(0, 7));
            digits_0 = 16'($urandom);
            digits_1 = 16'($urandom);
            digits_2 = 16'($urandom);
            cycles($urandom_range(1, 15));
        end
        // Asynchronous reset in the middle of a grant
        req = 3'b000;
        cycles(6);
        req = 3'b001;
        cycles(6);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 direct_check("async_reset", {grant, an, seg}, {3'b000, 4'b1111, 7'b1111111});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(12);
        req = 3'b000;
        cycles(4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 4-digit seven-segment display between up to three requesters (value entry, bubble sort, selection sort) using request/grant arbitration. Each owner holds the display for a minimum time, round-robin fairness applies between owners, and a blanking gap separates owners. The block also runs the digit-scan multiplexing and BCD-to-segment decode for the granted owner. It sits between the sorting engines and the top-level `seg`/`an` pins.

## Interface
- `SCAN_BITS`, 17: scan counter width; the top 2 bits select the digit.
- `HOLD_CYCLES`, 50_000_000: minimum grant time before another requester may preempt the owner.
- `BLANK_CYCLES`, 5_000_000: length of the blank gap between owners.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req` in 3: requests. Bit 0 = entry, bit 1 = bubble, bit 2 = selection. Level-sensitive.
- `digits_0` in 16: entry digits, four BCD nibbles. [15:12] is the leftmost digit.
- `digits_1` in 16: bubble digits, same packing.
- `digits_2` in 16: selection digits, same packing.
- `grant` out 3: one-hot grant, or 000 when nobody owns the display.
- `seg` out 7: segment drive, active-low, registered.
- `an` out 4: anode drive, active-low, registered.

## Operation
- States: IDLE, GRANT, BLANK.
- Reset values:
  - state = IDLE, grant = 000, an = 1111, seg = 1111111.
  - scan counter = 0, hold counter = 0, blank counter = 0, last_owner = 2 (so requester 0 has first priority).
- IDLE:
  - If req ≠ 000, pick the owner round-robin, go to GRANT and load grant.
  - There is no blank gap when leaving IDLE.
- Round-robin: search from last_owner+1 upward, mod 3. The first set req bit wins, and last_owner is updated to it.
- GRANT:
  - The hold counter starts at 0 on entry and increments every cycle, saturating at HOLD_CYCLES.
  - Exit to BLANK when the owner's req bit is 0.
  - Also exit to BLANK when any other req bit is 1 and the hold counter equals HOLD_CYCLES.
  - Only other requesters can preempt; the owner's own req never triggers preemption.
  - If both exit conditions occur in the same cycle, the result is a single transition to BLANK.
- BLANK:
  - grant = 000 and the blank counter runs BLANK_CYCLES cycles.
  - At expiry, if req ≠ 000 apply round-robin and go to GRANT, else go to IDLE.
  - A previous owner that re-asserts req during BLANK is an ordinary requester; round-robin still favours the others.
- Digit scan:
  - The SCAN_BITS counter is free-running from reset in all states and wraps naturally.
  - Top 2 bits select the digit and nibble: 00 → an 0111, [15:12]; 01 → an 1011, [11:8]; 10 → an 1101, [7:4]; 11 → an 1110, [3:0].
  - The nibble comes from the digits bus of the granted requester.
- Decode (active-low gfedcba):
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000
  - Nibbles 10–15 → 1111111, with the anode still driven.
- In IDLE and BLANK (grant = 000): an = 1111, seg = 1111111.

## Timing
- `req` is sampled on the rising edge of `clk`. `grant` is registered.
  - From IDLE, grant asserts on the first edge at which req is seen.
  - From GRANT, grant drops to 000 on the edge that enters BLANK.
- `seg` and `an` are registered from the current grant, scan count and digits, so they lag those inputs by one cycle.
  - The first active `an` appears one edge after `grant` asserts.
  - The first blanked `an` appears one edge after `grant` drops.
- A digit change on the owner's bus reaches `seg` one cycle later. No latching; the display follows live data.
- Grant length is at least HOLD_CYCLES+1 cycles under preemption, unless the owner drops req earlier.
- The blank gap is exactly BLANK_CYCLES cycles of grant = 000.
- Asserting `rst_n` low forces all reset values immediately, with no clock edge needed, including mid-GRANT or mid-BLANK.
- Deassertion of `rst_n` is synchronised externally; the first active edge after release sees state IDLE.

## Test plan
Benches use SCAN_BITS=4, HOLD_CYCLES=8, BLANK_CYCLES=3.
- Reset, then hold req=000: grant=000, an=1111, seg=1111111 throughout; the scan counter advances without driving `an`.
- req=010 with digits_1=16'h1234:
  - grant=010 on the next edge.
  - an cycles 0111→1011→1101→1110, 4 cycles each.
  - seg reads 1111001, 0100100, 0110000, 0011001 respectively.
- Owner 0 granted, req goes 001→011 at hold count 2:
  - grant stays 001 until hold count 8, then is 000 for exactly 3 cycles (an=1111).
  - grant then becomes 010.
- req=111 held continuously from reset: grant sequence 001, 010, 100, 001, each 9 cycles, separated by 3-cycle blanks.
- Owner 2 granted with digits_2=16'h0A0F:
  - the an=0111 phase shows seg=1000000;
  - the an=1011 and an=1110 phases show seg=1111111;
  - the an=1101 phase shows seg=1000000.
- Drop `rst_n` asynchronously between edges during GRANT: grant, an and seg take reset values before the next edge. After release with req=001, grant=001 on the first edge.
